// File: rtl/line_rev_stack_if.sv
// Pixel stream bundle for line_rev_stack: input beat handshake plus reversed output.
// The master modport belongs to the producer/consumer side; the slave modport belongs to the stack.
interface line_rev_stack_if #(
  parameter int unsigned DWIDTH = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] din;
  logic              out_valid;
  logic              out_last;
  logic [DWIDTH-1:0] dout;

  modport master (
    output in_valid, din,
    input  in_ready, out_valid, dout, out_last
  );

  modport slave (
    input  in_valid, din,
    output in_ready, out_valid, dout, out_last
  );
endinterface

// File: rtl/line_rev_stack.sv
// Line-reversal LIFO: each line is written over the previous one in the opposite sweep direction,
// so the read-first data reads back the previous line reversed. Define STACK_FLUSH_EN for the drain path.
module line_rev_stack #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned AWIDTH    = 11,
  parameter int unsigned MAX_WIDTH = 1936
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [AWIDTH-1:0] width,
  input  logic              flush,
  line_rev_stack_if.slave   bus
);

  localparam logic [AWIDTH:0] W_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0] W_MAX = (AWIDTH+1)'(MAX_WIDTH);

  logic [DWIDTH-1:0] mem [MAX_WIDTH];

  logic [AWIDTH-1:0] ptr;
  logic [AWIDTH-1:0] ptr_step;
  logic              dir;
  logic              primed;
  logic [AWIDTH:0]   cnt;
  logic [AWIDTH:0]   w_lat;
  logic [AWIDTH:0]   w_eff;
  logic [AWIDTH:0]   w_cur;
  logic              idle;
  logic              last;
  logic              run;
  logic              acc;
  logic              drain;
  logic              emit;

  logic              out_valid_q;
  logic              out_last_q;
  logic [DWIDTH-1:0] dout_q;

  // A beat taken while idle must already see the width being latched in the same cycle.
  always_comb begin
    idle = (cnt == '0) && !primed;
    if (width == '0)
      w_eff = W_ONE;
    else if ({1'b0, width} > W_MAX)
      w_eff = W_MAX;
    else
      w_eff = {1'b0, width};
    w_cur    = idle ? w_eff : w_lat;
    last     = (cnt == (w_cur - W_ONE));
    acc      = clken && bus.in_valid && run;
    drain    = clken && !run;
    emit     = (acc && primed) || drain;
    ptr_step = dir ? (ptr - AWIDTH'(1)) : (ptr + AWIDTH'(1));
  end

`ifdef STACK_FLUSH_EN
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else if (clken)
      state <= state_nxt;
  end

  // An input beat arriving together with flush wins; the flush request is then dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush && (cnt == '0) && primed && !acc) state_nxt = FLUSH;
      FLUSH:   if (last) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign run          = (state == RUN);
  assign bus.in_ready = run;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign run          = 1'b1;
  assign bus.in_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (acc)
      mem[ptr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      dir         <= 1'b0;
      cnt         <= '0;
      w_lat       <= W_ONE;
      primed      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      dout_q      <= '0;
    end else if (clken) begin
      if (idle && run)
        w_lat <= w_eff;
      out_valid_q <= emit;
      out_last_q  <= emit && last;
      if (acc || drain)
        dout_q <= mem[ptr];
      if (acc) begin
        if (last) begin
          cnt    <= '0;
          primed <= 1'b1;
          dir    <= !dir;
        end else begin
          cnt <= cnt + W_ONE;
          ptr <= ptr_step;
        end
      end else if (drain) begin
        if (last) begin
          cnt    <= '0;
          primed <= 1'b0;
          dir    <= 1'b0;
          ptr    <= '0;
        end else begin
          cnt <= cnt + W_ONE;
          ptr <= ptr_step;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.dout      = dout_q;

endmodule

// File: doc/line_rev_stack.md
# line_rev_stack

Parametrised line-reversal LIFO for the SGM post-processing path. It stores one image line of up to MAX_WIDTH pixels and streams it back in reverse pixel order while the next line is written. This supports right-to-left passes (aggregation directions, left-right consistency) without a second buffer. Line width is set at runtime, and an optional flush drains the final line of a frame with no further input.

## Interface
- DWIDTH, 16, pixel/data width in bits.
- AWIDTH, 11, address width; must satisfy 2^AWIDTH >= MAX_WIDTH.
- MAX_WIDTH, 1936, memory depth in pixels and largest legal line width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clken  in  1  global clock enable; when low, all state and outputs hold.
- width  in  AWIDTH  line width in pixels; sampled only while idle (see Operation).
- in_valid  in  1  input pixel strobe; a beat is accepted when clken & in_valid & in_ready.
- din  in  DWIDTH  input pixel.
- in_ready  out  1  high when input beats can be accepted; low only during flush.
- flush  in  1  single-cycle request to drain the stored line (STACK_FLUSH_EN only).
- out_valid  out  1  dout carries a reversed pixel this cycle.
- dout  out  DWIDTH  reversed pixel.
- out_last  out  1  with out_valid: last pixel of a reversed line (the original pixel 0).

## Operation
- Memory: internal MAX_WIDTH x DWIDTH single-address array.
  - Read-first: a read and a write to the same address in one cycle return the old data.
  - Registered read, 1-cycle latency.
- State:
  - ptr (AWIDTH)
  - dir (0 = ascending, 1 = descending)
  - cnt (pixels accepted in the current line)
  - w_lat (latched width)
  - primed (a complete line is stored)
  - FSM {RUN, FLUSH}
- Idle means cnt==0 && primed==0. Only then is width sampled into w_lat.
  - width==0 is latched as 1.
  - width>MAX_WIDTH is latched as MAX_WIDTH.
- Accepted beat in RUN:
  - Write din at ptr and read ptr in the same cycle.
  - cnt increments.
  - ptr steps +1 if dir==0, −1 if dir==1, except on the last beat of a line.
- Line end (cnt reaches w_lat−1 on an accepted beat):
  - cnt←0, primed←1, dir toggles, ptr holds.
  - The next line therefore starts at the same end and sweeps back.
  - Reading at the write address thus yields the previous line reversed.
- Output:
  - out_valid=1 one cycle after an accepted beat made while primed==1.
  - out_last marks the beat whose address is the final address of the sweep.
- FLUSH (compiled in only):
  - Entered when flush && cnt==0 && primed==1.
  - in_ready=0 during FLUSH.
  - One read per clken cycle with no write, stepping ptr in the same sweep a new line would use.
  - After w_lat reads: primed←0, dir←0, ptr←0, return to RUN, in_ready←1 the next cycle.
- flush with cnt!=0 or primed==0 is ignored.
- in_valid during FLUSH is ignored; it does not stall the drain.
- No output backpressure. The consumer must take every out_valid beat.

## Timing
- Reset values: out_valid 0, dout 0, out_last 0, in_ready 1, ptr 0, dir 0, cnt 0, primed 0, FSM RUN.
- Latency: pixel k of line n appears 1 cycle after input beat (w_lat−1−k) of line n+1.
- Throughput: 1 pixel/cycle in and out; flush drains in w_lat cycles plus 1 output-latency cycle.
- clken low:
  - No pointer or FSM update.
  - out_valid, dout and out_last hold their values and must not be re-counted by the consumer.
- Reset mid-line or mid-flush: all state returns to reset values and stored data is discarded.
- w_lat==1: every beat is a line end; dir toggles each beat and out_last accompanies every output.

## Configuration
- STACK_FLUSH_EN
  - Defined: FLUSH state and logic as above.
  - Undefined: flush is ignored, in_ready is tied 1, and the last line of a frame is emitted only when another line is written.

## Test plan
- Reset, width=4, write lines A=1,2,3,4 and B=5,6,7,8 back-to-back → during B, out 4,3,2,1 with out_last on 1; dir toggles, ptr sweeps 3,2,1,0.
- Three lines at width=1920 → line 1 reversed during line 2, line 2 reversed during line 3; out_valid never set during line 1.
- Random clken/in_valid gaps, width=7 → same output sequence as the gap-free run; outputs hold while clken=0.
- STACK_FLUSH_EN, width=5, one line 10..14 then flush → in_ready low for 5 cycles, out 14,13,12,11,10 with out_last on 10; afterwards a new width=3 is latched.
- flush mid-line (cnt=2) → ignored, no output, in_ready stays 1; rst asserted mid-flush → all outputs 0 next cycle, in_ready 1.
- width=0 and width=2000 → behave as width 1 and width 1936 respectively.
